// File: rtl/cordic_angle_reduce_pkg.sv
// Shared constants and controller state encoding for the CORDIC sine/cosine datapath.
// Angles are signed fixed point with FRAC fractional bits, in radians.
package cordic_angle_reduce_pkg;

    localparam int FRAC  = 23;
    localparam int OUT_W = 27;

    localparam logic [OUT_W-1:0] PI     = 27'h1921FB5;
    localparam logic [OUT_W-1:0] TWO_PI = 27'h3243F6A;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REDUCE = 3'd1;
    localparam logic [2:0] ST_FOLD   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;

endpackage

// File: rtl/cordic_angle_reduce_step.sv
// Combinational conditional add/subtract used for both the 2*pi*2^k reduction
// steps and the final fold into [-pi, pi].
module cordic_mod2pi_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] thr,
    input  logic [W-1:0] step,
    input  logic         strict,
    output logic [W-1:0] r_next
);

    logic signed [W-1:0] r_sg;
    logic signed [W-1:0] thr_sg;
    logic                above_s;
    logic                below_s;

    assign r_sg   = $signed(r);
    assign thr_sg = $signed(thr);

    // strict comparison lets exactly +/-pi pass through the fold untouched
    always_comb begin
        if (strict) begin
            above_s = (r_sg > thr_sg);
            below_s = (r_sg < -thr_sg);
        end else begin
            above_s = (r_sg >= thr_sg);
            below_s = (r_sg <= -thr_sg);
        end
    end

    // move r one step toward zero when it lies outside the threshold band
    always_comb begin
        r_next = r;
        if (above_s) begin
            r_next = r - step;
        end else if (below_s) begin
            r_next = r + step;
        end else begin
            r_next = r;
        end
    end

endmodule

// File: rtl/cordic_angle_reduce.sv
// Reduces an arbitrary Q8.23 angle modulo 2*pi into [-pi, pi] and hands it to
// the CORDIC core with a one-cycle start, then waits for the core's done.
module cordic_angle_reduce #(
    parameter int IN_W  = 32,
    parameter int FRAC  = cordic_angle_reduce_pkg::FRAC,
    parameter int OUT_W = cordic_angle_reduce_pkg::OUT_W,
    parameter int ITER  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  angle_i,
    input  logic             cos_i,
    output logic             cordic_start,
    output logic [OUT_W-1:0] cordic_theta,
    output logic             cordic_cos,
    input  logic             cordic_done,
    output logic             busy
);

    import cordic_angle_reduce_pkg::PI;
    import cordic_angle_reduce_pkg::TWO_PI;
    import cordic_angle_reduce_pkg::ST_IDLE;
    import cordic_angle_reduce_pkg::ST_REDUCE;
    import cordic_angle_reduce_pkg::ST_FOLD;
    import cordic_angle_reduce_pkg::ST_ISSUE;
    import cordic_angle_reduce_pkg::ST_WAIT;

    // one extra bit so TWO_PI << (ITER-1) cannot overflow
    localparam int W  = IN_W + 1;
    localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [W-1:0] PI_W     = W'(PI);
    localparam logic [W-1:0] TWO_PI_W = W'(TWO_PI);

    if (FRAC != cordic_angle_reduce_pkg::FRAC) begin : g_frac_chk
        $error("angle constants are fixed at the package FRAC");
    end
    if ((longint'(TWO_PI) << ITER) <= (64'sd1 <<< (IN_W - 1))) begin : g_iter_chk
        $error("ITER too small to cover the input range");
    end

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [W-1:0]     r_r;
    logic [W-1:0]     r_s;
    logic [KW-1:0]    k_r;
    logic [KW-1:0]    k_s;
    logic             cos_q_r;
    logic             cos_q_s;
    logic [OUT_W-1:0] theta_r;
    logic [OUT_W-1:0] theta_s;
    logic             start_r;
    logic             busy_r;
    logic             ready_r;

    logic [W-1:0]     t_k_s;
    logic [W-1:0]     thr_s;
    logic [W-1:0]     step_s;
    logic             strict_s;
    logic [W-1:0]     step_out_s;

    assign t_k_s = TWO_PI_W << k_r;

    // FOLD tests against pi and moves by 2*pi; REDUCE uses T_k for both
    always_comb begin
        if (state_r == ST_FOLD) begin
            thr_s    = PI_W;
            step_s   = TWO_PI_W;
            strict_s = 1'b1;
        end else begin
            thr_s    = t_k_s;
            step_s   = t_k_s;
            strict_s = 1'b0;
        end
    end

    cordic_mod2pi_step #(
        .W(W)
    ) u_step (
        .r      (r_r),
        .thr    (thr_s),
        .step   (step_s),
        .strict (strict_s),
        .r_next (step_out_s)
    );

    // next-state and datapath selection for the reduction sequence
    always_comb begin
        state_s = state_r;
        r_s     = r_r;
        k_s     = k_r;
        cos_q_s = cos_q_r;
        theta_s = theta_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    r_s     = {angle_i[IN_W-1], angle_i};
                    cos_q_s = cos_i;
                    k_s     = KW'(ITER - 1);
                    state_s = ST_REDUCE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REDUCE: begin
                r_s = step_out_s;
                if (k_r == {KW{1'b0}}) begin
                    state_s = ST_FOLD;
                end else begin
                    k_s = k_r - KW'(1);
                end
            end
            ST_FOLD: begin
                r_s     = step_out_s;
                theta_s = step_out_s[OUT_W-1:0];
                state_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cordic_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // state and registered outputs; everything holds while clk_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            r_r     <= {W{1'b0}};
            k_r     <= {KW{1'b0}};
            cos_q_r <= 1'b0;
            theta_r <= {OUT_W{1'b0}};
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else if (clk_en) begin
            state_r <= state_s;
            r_r     <= r_s;
            k_r     <= k_s;
            cos_q_r <= cos_q_s;
            theta_r <= theta_s;
            start_r <= (state_s == ST_ISSUE);
            busy_r  <= (state_s != ST_IDLE);
            ready_r <= (state_s == ST_IDLE);
        end
    end

    assign in_ready     = ready_r;
    assign busy         = busy_r;
    assign cordic_start = start_r;
    assign cordic_theta = theta_r;
    assign cordic_cos   = cos_q_r;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Self-checking bench for cordic_angle_reduce: vector table driven through a
// scoreboard, plus clock-enable, back-pressure and mid-operation reset sequences.
module tb_cordic_angle_reduce;

    localparam longint PI_I     = 64'sd26353589;
    localparam longint TWO_PI_I = 64'sd52707178;
    localparam int     NV       = 13;

    typedef struct {
        logic [31:0] angle;
        logic        cos;
        logic [26:0] theta;
    } vec_t;

    typedef struct {
        logic [26:0] theta;
        logic        cos;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle_i;
    logic        cos_i;
    logic        cordic_start;
    logic [26:0] cordic_theta;
    logic        cordic_cos;
    logic        cordic_done;
    logic        busy;

    vec_t   vecs [NV];
    exp_t   sb_q [$];
    longint lat_q [$];
    int     checks = 0;
    int     errors = 0;
    int     starts_seen = 0;
    int     n_starts = 0;
    longint en_cnt = 0;
    logic   last_en = 1'b0;
    bit     toggle_en = 1'b0;

    always #5 clk = ~clk;

    cordic_angle_reduce dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .angle_i      (angle_i),
        .cos_i        (cos_i),
        .cordic_start (cordic_start),
        .cordic_theta (cordic_theta),
        .cordic_cos   (cordic_cos),
        .cordic_done  (cordic_done),
        .busy         (busy)
    );

    function automatic logic [26:0] ref_theta(input logic [31:0] a);
        longint m;
        m = longint'($signed(a)) % TWO_PI_I;
        if (m < 0) m = m + TWO_PI_I;
        if (m > PI_I) m = m - TWO_PI_I;
        return m[26:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clk_en = toggle_en ? ~clk_en : 1'b1;
    endtask

    // Scoreboard: counts enabled edges, records acceptances, pops on each enabled start cycle
    always @(negedge clk) begin
        exp_t   e;
        longint a;
        en_cnt  = en_cnt + (last_en ? 64'sd1 : 64'sd0);
        last_en = clk_en;
        if (rst) begin
            sb_q.delete();
            lat_q.delete();
        end else begin
            if (cordic_start && clk_en) begin
                starts_seen++;
                check("start_expected", {31'd0, (sb_q.size() != 0) && (lat_q.size() != 0)}, 32'd1);
                if (sb_q.size() != 0 && lat_q.size() != 0) begin
                    e = sb_q.pop_front();
                    a = lat_q.pop_front();
                    check("theta", {5'd0, cordic_theta}, {5'd0, e.theta});
                    check("cos", {31'd0, cordic_cos}, {31'd0, e.cos});
                    check("latency", 32'(en_cnt - a), 32'd8);
                end
            end
            if (in_valid && in_ready && clk_en) lat_q.push_back(en_cnt);
        end
    end

    task automatic start_txn(input logic [31:0] a, input logic c, input logic [26:0] t);
        exp_t e;
        for (int i = 0; i < 50 && !(in_ready && clk_en); i++) tick();
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        angle_i  = a;
        cos_i    = c;
        e.theta  = t;
        e.cos    = c;
        sb_q.push_back(e);
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_start(input int target);
        for (int i = 0; i < 100 && starts_seen < target; i++) tick();
        check("start_seen", starts_seen, target);
    endtask

    task automatic pulse_done();
        for (int i = 0; i < 4 && !clk_en; i++) tick();
        cordic_done = 1'b1;
        tick();
        cordic_done = 1'b0;
    endtask

    task automatic finish_txn();
        n_starts++;
        wait_start(n_starts);
        tick();
        check("busy_in_wait", {31'd0, busy}, 32'd1);
        check("ready_in_wait", {31'd0, in_ready}, 32'd0);
        pulse_done();
        check("ready_after_done", {31'd0, in_ready}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        clk_en      = 1'b1;
        in_valid    = 1'b0;
        angle_i     = 32'd0;
        cos_i       = 1'b0;
        cordic_done = 1'b0;

        vecs[0]  = '{32'h00000000, 1'b1, 27'd0};
        vecs[1]  = '{32'h02000000, 1'b0, 27'h6DBC096};
        vecs[2]  = '{32'h7FFFFFFF, 1'b1, 27'(-32'sd13510651)};
        vecs[3]  = '{32'h80000000, 1'b0, 27'd13510650};
        vecs[4]  = '{32'h01921FB5, 1'b1, 27'd26353589};
        vecs[5]  = '{32'hFE6DE04B, 1'b0, 27'(-32'sd26353589)};
        vecs[6]  = '{32'h12345678, 1'b1, ref_theta(32'h12345678)};
        vecs[7]  = '{32'hF0000000, 1'b0, ref_theta(32'hF0000000)};
        vecs[8]  = '{32'h03243F6A, 1'b1, 27'd0};
        vecs[9]  = '{32'h04B65F1F, 1'b0, 27'd26353589};
        vecs[10] = '{32'(-32'sd79060767), 1'b1, 27'(-32'sd26353589)};
        vecs[11] = '{32'hFFFFFFFF, 1'b0, ref_theta(32'hFFFFFFFF)};
        vecs[12] = '{32'h01921FB6, 1'b1, ref_theta(32'h01921FB6)};

        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, cordic_start}, 32'd0);
        check("rst_theta", {5'd0, cordic_theta}, 32'd0);
        check("rst_cos", {31'd0, cordic_cos}, 32'd0);

        for (int v = 0; v < NV; v++) begin
            start_txn(vecs[v].angle, vecs[v].cos, vecs[v].theta);
            finish_txn();
        end

        // clock enable alternating every cycle
        toggle_en = 1'b1;
        for (int v = 1; v < 3; v++) begin
            start_txn(vecs[v].angle, vecs[v].cos, vecs[v].theta);
            finish_txn();
        end
        toggle_en = 1'b0;
        tick();

        // request held through WAIT: no second start until done, then accepted at once
        start_txn(vecs[6].angle, vecs[6].cos, vecs[6].theta);
        in_valid = 1'b1;
        angle_i  = vecs[7].angle;
        cos_i    = vecs[7].cos;
        n_starts++;
        wait_start(n_starts);
        repeat (6) tick();
        check("held_no_second_start", starts_seen, n_starts);
        check("held_ready_low", {31'd0, in_ready}, 32'd0);
        sb_q.push_back('{vecs[7].theta, vecs[7].cos});
        pulse_done();
        check("held_ready_after_done", {31'd0, in_ready}, 32'd1);
        tick();
        check("held_accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        finish_txn();

        // reset during WAIT; the later done must be ignored
        start_txn(vecs[2].angle, vecs[2].cos, vecs[2].theta);
        n_starts++;
        wait_start(n_starts);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstwait_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstwait_busy", {31'd0, busy}, 32'd0);
        check("rstwait_start", {31'd0, cordic_start}, 32'd0);
        repeat (2) tick();
        cordic_done = 1'b1;
        tick();
        cordic_done = 1'b0;
        repeat (12) tick();
        check("rstwait_no_start", starts_seen, n_starts);
        check("rstwait_idle_busy", {31'd0, busy}, 32'd0);
        check("rstwait_idle_ready", {31'd0, in_ready}, 32'd1);

        start_txn(vecs[3].angle, vecs[3].cos, vecs[3].theta);
        finish_txn();

        repeat (3) tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_angle_reduce.md
Name: cordic_angle_reduce

Overview:
- Upstream stage of the CORDIC sine/cosine core.
- Accepts an arbitrary signed fixed-point angle (Q8.23, radians) with a sin/cos select, and reduces it modulo 2π into [-π, π] in Q4.23.
- Issues a one-cycle start to the CORDIC core, then holds off new requests until the core reports done.
- The core itself only folds [-π, π] into ±π/2, so this block extends the usable input range to ±256 rad.

Parameters:
- IN_W, 32, input angle width (signed, FRAC fractional bits).
- FRAC, 23, fractional bits, shared by input and output.
- OUT_W, 27, output angle width (signed Q4.23), matches the core's theta.
- ITER, 6, reduction iterations. Must satisfy 2π·2^ITER > 2^(IN_W-1-FRAC).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  global clock enable; all state advances only when high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- angle_i  in  IN_W  signed angle, Q8.23 rad
- cos_i  in  1  1 = cosine, 0 = sine
- cordic_start  out  1  start pulse to core
- cordic_theta  out  OUT_W  reduced angle to core
- cordic_cos  out  1  function select to core
- cordic_done  in  1  done pulse from core
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; cordic_start 0; cordic_theta 0; cordic_cos 0; busy 0; in_ready 1 once out of reset.
- Registers change only on clk_en-qualified edges. rst acts regardless of clk_en.
- States:
  - IDLE: in_ready=1. On in_valid & clk_en: r <= sign-extended angle_i (IN_W+1 bits); cos_q <= cos_i; k <= ITER-1; go to REDUCE.
  - REDUCE, one iteration per enabled cycle, T_k = TWO_PI<<k:
    - if r >= T_k then r -= T_k;
    - else if r <= -T_k then r += T_k;
    - else r unchanged.
    - After k=0, go to FOLD. The invariant |r| < T_k after step k gives |r| < 2π on exit.
  - FOLD:
    - if r > PI then r -= TWO_PI; else if r < -PI then r += TWO_PI.
    - Exactly +PI and -PI pass unchanged.
    - cordic_theta <= r[OUT_W-1:0] (lossless, since |r| ≤ π). Go to ISSUE.
  - ISSUE: cordic_start=1 for exactly one enabled cycle; then go to WAIT.
  - WAIT: on cordic_done go to IDLE. cordic_done arriving in any other state is ignored.
- Stability: cordic_cos is driven from cos_q and cordic_theta is registered.
  - cordic_cos is stable from the cycle after acceptance until the next acceptance.
  - cordic_theta is stable from FOLD until the next acceptance.
  - This meets the core's requirement that the select be valid while it is idle and the angle be valid at start.
- Latency, in enabled cycles: accept → start = ITER+2 (8 at default). No new acceptance until done is returned.
- Arithmetic:
  - Internal width IN_W+1, so that T_{ITER-1} does not overflow.
  - TWO_PI = 27'h3243F6A (PI<<1); PI = 27'h1921FB5, sign-extended.
- Reset mid-operation returns to IDLE immediately with no start issued. A core already running finishes on its own; its done is ignored in IDLE.
- clk_en low freezes all state, including a pending start.

Decomposition:
- Shared package holds PI, TWO_PI, the state encoding, and FRAC/OUT_W. The CORDIC core's constants are moved to the same package.
- Natural sub-module: cordic_mod2pi_step, a combinational conditional add/subtract of T_k. It is reused for REDUCE (shift k) and for FOLD.
- Optional top wrapper cordic_top instances this block plus the core.

Test Plan:
- angle_i=0, cos_i=1 → cordic_theta=0, cordic_cos=1, start exactly 8 enabled cycles after accept, single pulse.
- angle_i=0x02000000 (4.0 rad) → cordic_theta = -19152746 (27'h6DBC096).
- angle_i=0x7FFFFFFF → cordic_theta = -13510651; angle_i=0x80000000 → cordic_theta = +13510650.
- angle_i=+PI (0x01921FB5) → cordic_theta=26353589 unchanged; angle_i=-PI → cordic_theta=-26353589 unchanged.
- in_valid held high through WAIT → in_ready=0 and no second start until cordic_done pulses; then accepted next enabled cycle.
- clk_en toggled 1/0 every cycle → same results at 2× latency. rst asserted in WAIT → IDLE, in_ready=1 next cycle, later done ignored.
